// File: rtl/calc_pkg.sv
// Shared types and constants for the operand-collection controller.
// State encoding and the one-hot datapath load strobes live here so the bench and RTL agree.
package calc_pkg;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_C    = 3'd2,
        S_D    = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [2:0] CAP_A = 3'b001;
    localparam logic [2:0] CAP_B = 3'b010;
    localparam logic [2:0] CAP_C = 3'b100;

endpackage

// File: rtl/calc_op_counter.sv
// Free-running count of completed operations.
// Wraps silently at 2^CNT_W.
module calc_op_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + ONE;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/calc_controller.sv
// Sequences four operands into datapath registers A/B/C and then issues the compute strobe.
// Strobes are combinational from state/valid/abort so the datapath loads on the valid edge.
//
//   state  | meaning
//   S_A    | idle, next operand loads A
//   S_B    | A held, next operand loads B
//   S_C    | A/B held, next operand loads C
//   S_D    | A/B/C held, next operand triggers (A+B)-(C+operand)
//   S_DONE | datapath result valid, done pulses, operands ignored
module calc_controller
    import calc_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             valid,
    input  logic             abort,
    output logic [2:0]       capture,
    output logic             op,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] op_count
);

    state_t r_state;
    state_t w_next_state;

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_state <= S_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        capture      = '0;
        op           = 1'b0;
        ready        = 1'b1;
        busy         = 1'b1;
        done         = 1'b0;

        case (r_state)
            S_A: begin
                busy = 1'b0;
                if (!abort && valid) begin
                    capture      = CAP_A;
                    w_next_state = S_B;
                end
            end
            S_B: begin
                if (abort) begin
                    w_next_state = S_A;
                end else if (valid) begin
                    capture      = CAP_B;
                    w_next_state = S_C;
                end
            end
            S_C: begin
                if (abort) begin
                    w_next_state = S_A;
                end else if (valid) begin
                    capture      = CAP_C;
                    w_next_state = S_D;
                end
            end
            S_D: begin
                if (abort) begin
                    w_next_state = S_A;
                end else if (valid) begin
                    op           = 1'b1;
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                // abort is ignored here so a finished result is never thrown away
                ready        = 1'b0;
                done         = 1'b1;
                w_next_state = S_A;
            end
            default: begin
                w_next_state = S_A;
            end
        endcase

        if (!rst_n) begin
            capture = '0;
            op      = 1'b0;
            done    = 1'b0;
            busy    = 1'b0;
        end
    end

    calc_op_counter #(
        .CNT_W (CNT_W)
    ) u_op_counter (
        .clock (clock),
        .rst_n (rst_n),
        .inc   (op),
        .count (op_count)
    );

endmodule

// File: tb/tb_calc_controller.sv
// Directed bench for calc_controller with a small datapath model and a result scoreboard.
// Expected results are queued when the operands are driven and popped when done pulses.
module tb_calc_controller;

    localparam int CNT_W = 8;

    logic             clock = 1'b0;
    logic             rst_n;
    logic             valid;
    logic             abort;
    logic [3:0]       bus;
    logic [2:0]       capture;
    logic             op;
    logic             ready;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] op_count;

    logic [3:0] dp_a, dp_b, dp_c;
    logic [4:0] dp_res;

    logic [6:0]       s_vec;
    logic [CNT_W-1:0] s_cnt;

    logic [4:0] exp_q[$];
    int n_checks = 0;
    int n_err    = 0;

    always #5 clock = ~clock;

    calc_controller #(.CNT_W(CNT_W)) dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .valid    (valid),
        .abort    (abort),
        .capture  (capture),
        .op       (op),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .op_count (op_count)
    );

    // Datapath driven only by the controller's strobes
    always @(posedge clock) begin
        if (capture[0]) dp_a <= bus;
        if (capture[1]) dp_b <= bus;
        if (capture[2]) dp_c <= bus;
        if (op)         dp_res <= 5'(dp_a) + 5'(dp_b) - 5'(dp_c) - 5'(bus);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, sample at negedge, score any done pulse
    task automatic step(input logic v, input logic ab, input logic [3:0] d);
        logic [4:0] exp_r;
        valid = v;
        abort = ab;
        bus   = d;
        @(negedge clock);
        s_vec = {capture, op, ready, busy, done};
        s_cnt = op_count;
        chk("onehot_strobes", 32'($countones({capture, op}) <= 1), 32'd1);
        if (done) begin
            chk("done_has_expect", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp_r = exp_q.pop_front();
                chk("result", 32'(dp_res), 32'(exp_r));
            end
        end
        @(posedge clock);
        #1;
    endtask

    // s_vec = {capture[2:0], op, ready, busy, done}
    task automatic full_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                           input logic [3:0] d, input logic [4:0] exp_r);
        exp_q.push_back(exp_r);
        step(1'b1, 1'b0, a);     chk("cap_a",  32'(s_vec), 32'(7'b001_0_1_0_0));
        step(1'b1, 1'b0, b);     chk("cap_b",  32'(s_vec), 32'(7'b010_0_1_1_0));
        step(1'b1, 1'b0, c);     chk("cap_c",  32'(s_vec), 32'(7'b100_0_1_1_0));
        step(1'b1, 1'b0, d);     chk("op",     32'(s_vec), 32'(7'b000_1_1_1_0));
        step(1'b1, 1'b0, 4'hF);  chk("done",   32'(s_vec), 32'(7'b000_0_0_1_1));
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        abort = 1'b0;
        bus   = '0;
        repeat (2) @(posedge clock);
        #1;

        // Reset held: strobes and busy forced low despite valid/abort
        step(1'b1, 1'b1, 4'd7);
        chk("reset_outputs", 32'(s_vec), 32'(7'b000_0_1_0_0));
        chk("reset_count",   32'(s_cnt), 32'd0);
        rst_n = 1'b1;

        // Back-to-back operands 3,5,2,1 -> (3+5)-(2+1) = 5
        full_op(4'd3, 4'd5, 4'd2, 4'd1, 5'd5);
        chk("cnt_after_first", 32'(s_cnt), 32'd1);

        // Two idle cycles between operands 7,2,4,1 -> 9-5 = 4
        exp_q.push_back(5'd4);
        step(1'b1, 1'b0, 4'd7); chk("gap_cap_a", 32'(s_vec), 32'(7'b001_0_1_0_0));
        repeat (2) begin step(1'b0, 1'b0, 4'd0); chk("gap_hold_b", 32'(s_vec), 32'(7'b000_0_1_1_0)); end
        step(1'b1, 1'b0, 4'd2); chk("gap_cap_b", 32'(s_vec), 32'(7'b010_0_1_1_0));
        repeat (2) begin step(1'b0, 1'b0, 4'd0); chk("gap_hold_c", 32'(s_vec), 32'(7'b000_0_1_1_0)); end
        step(1'b1, 1'b0, 4'd4); chk("gap_cap_c", 32'(s_vec), 32'(7'b100_0_1_1_0));
        repeat (2) begin step(1'b0, 1'b0, 4'd0); chk("gap_hold_d", 32'(s_vec), 32'(7'b000_0_1_1_0)); end
        step(1'b1, 1'b0, 4'd1); chk("gap_op",    32'(s_vec), 32'(7'b000_1_1_1_0));
        step(1'b0, 1'b0, 4'd0); chk("gap_done",  32'(s_vec), 32'(7'b000_0_0_1_1));
        chk("cnt_after_gap", 32'(s_cnt), 32'd2);

        // Abort with valid while in S_C
        step(1'b1, 1'b0, 4'd1); chk("ab_cap_a", 32'(s_vec), 32'(7'b001_0_1_0_0));
        step(1'b1, 1'b0, 4'd2); chk("ab_cap_b", 32'(s_vec), 32'(7'b010_0_1_1_0));
        step(1'b1, 1'b1, 4'd3); chk("ab_in_c",  32'(s_vec), 32'(7'b000_0_1_1_0));
        step(1'b0, 1'b0, 4'd0); chk("ab_to_a",  32'(s_vec), 32'(7'b000_0_1_0_0));
        chk("ab_cnt_kept", 32'(s_cnt), 32'd2);
        // (6+1)-(1+2) = 4
        full_op(4'd6, 4'd1, 4'd1, 4'd2, 5'd4);
        chk("cnt_after_abort", 32'(s_cnt), 32'd3);

        // Abort with valid while in S_DONE: (9+9)-(3+3) = 12
        exp_q.push_back(5'd12);
        step(1'b1, 1'b0, 4'd9); chk("dab_cap_a", 32'(s_vec), 32'(7'b001_0_1_0_0));
        step(1'b1, 1'b0, 4'd9); chk("dab_cap_b", 32'(s_vec), 32'(7'b010_0_1_1_0));
        step(1'b1, 1'b0, 4'd3); chk("dab_cap_c", 32'(s_vec), 32'(7'b100_0_1_1_0));
        step(1'b1, 1'b0, 4'd3); chk("dab_op",    32'(s_vec), 32'(7'b000_1_1_1_0));
        step(1'b1, 1'b1, 4'd5); chk("dab_done",  32'(s_vec), 32'(7'b000_0_0_1_1));
        step(1'b0, 1'b0, 4'd0); chk("dab_to_a",  32'(s_vec), 32'(7'b000_0_1_0_0));
        chk("cnt_after_dab", 32'(s_cnt), 32'd4);

        // Reset pulse while in S_D with valid high
        step(1'b1, 1'b0, 4'd1); chk("rst_cap_a", 32'(s_vec), 32'(7'b001_0_1_0_0));
        step(1'b1, 1'b0, 4'd2); chk("rst_cap_b", 32'(s_vec), 32'(7'b010_0_1_1_0));
        step(1'b1, 1'b0, 4'd3); chk("rst_cap_c", 32'(s_vec), 32'(7'b100_0_1_1_0));
        rst_n = 1'b0;
        step(1'b1, 1'b0, 4'd4); chk("rst_in_d",  32'(s_vec), 32'(7'b000_0_1_0_0));
        rst_n = 1'b1;
        step(1'b0, 1'b0, 4'd0); chk("rst_idle",  32'(s_vec), 32'(7'b000_0_1_0_0));
        chk("rst_cnt_cleared", 32'(s_cnt), 32'd0);
        step(1'b1, 1'b0, 4'd5); chk("rst_first_cap", 32'(s_vec), 32'(7'b001_0_1_0_0));
        step(1'b0, 1'b1, 4'd0); chk("rst_abort_b",   32'(s_vec), 32'(7'b000_0_1_1_0));

        // 256 ops of 0,0,15,15 -> -30 mod 32 = 2; counter must wrap to 0
        for (int k = 1; k <= 256; k++) begin
            full_op(4'd0, 4'd0, 4'd15, 4'd15, 5'd2);
            chk("wrap_cnt", 32'(s_cnt), 32'(k % 256));
        end
        step(1'b0, 1'b0, 4'd0); chk("final_idle", 32'(s_vec), 32'(7'b000_0_1_0_0));
        chk("cnt_after_256", 32'(s_cnt), 32'd0);
        chk("queue_empty",   32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
